nirs_frame_packer: RTL and testbench

- Upstream neighbour of the FT232H send stage. Collects one detector scan of 24-bit ADC1278 samples (N_DET detectors for one active source) into a local buffer.
- Then serialises the scan as one framed byte packet into the shared 8-bit transmit FIFO. The send stage drains that FIFO to the host.
- Each frame enters the FIFO whole or not at all. The host parser therefore never sees a torn frame.

---
 rtl/nirs_pkg.sv | 22 ++
 rtl/nirs_sample_buf.sv | 25 ++
 rtl/nirs_frame_packer.sv | 204 ++++++++++++++++++++
 tb/tb_nirs_frame_packer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nirs_pkg.sv
// Shared definitions for the NIRS frame packer: sync bytes, frame sizing, FSM states.
package nirs_pkg;

    localparam int SAMPLE_W = 24;
    localparam logic [7:0] PKG_SYNC0 = 8'hA5;
    localparam logic [7:0] PKG_SYNC1 = 8'h5A;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COLLECT    = 3'd1,
        WAIT_SPACE = 3'd2,
        HEADER     = 3'd3,
        DATA       = 3'd4,
        CHECKSUM   = 3'd5
    } state_t;

    // Two sync bytes, frame count, source, 3 bytes per detector, checksum.
    function automatic int frame_bytes(input int n_det);
        return 3 * n_det + 5;
    endfunction

endpackage

// File: rtl/nirs_sample_buf.sv
// Simple dual-port scan buffer, one 24-bit word per detector, registered read.
module nirs_sample_buf
    import nirs_pkg::*;
#(
    parameter int N_DET = 32,
    parameter int AW    = (N_DET > 1) ? $clog2(N_DET) : 1
) (
    input  logic                clock,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [SAMPLE_W-1:0] rdata
);

    logic [SAMPLE_W-1:0] mem [N_DET];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/nirs_frame_packer.sv
// Buffers one detector scan and writes it as a single framed, checksummed packet
// into the shared byte FIFO, only once the whole frame is known to fit.
module nirs_frame_packer
    import nirs_pkg::*;
#(
    parameter int         N_DET      = 32,
    parameter int         FIFO_DEPTH = 8192,
    parameter logic [7:0] SYNC0      = PKG_SYNC0,
    parameter logic [7:0] SYNC1      = PKG_SYNC1
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                scan_start,
    input  logic [4:0]          source_idx,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic [12:0]         fifo_wrusedw,
    input  logic                fifo_full,
    output logic                fifo_wr_en,
    output logic [7:0]          fifo_data_in,
    output logic                busy,
    output logic [7:0]          frame_cnt,
    output logic                ovf_err
);

    localparam int            IW       = $clog2(N_DET + 1);
    localparam int            AW       = (N_DET > 1) ? $clog2(N_DET) : 1;
    localparam int            FB       = frame_bytes(N_DET);
    localparam logic [13:0]   DEPTH_14 = 14'(FIFO_DEPTH);
    localparam logic [13:0]   FB_14    = 14'(FB);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_DET - 1);

    state_t               state;
    state_t               state_nx;
    logic [IW-1:0]        sidx;
    logic [1:0]           bidx;
    logic [4:0]           src_q;
    logic [7:0]           csum;
    logic [13:0]          free_space;
    logic                 tx_active;
    logic                 accept;
    logic                 csum_add;
    logic [7:0]           tx_byte;
    logic                 ovf_set;
    logic                 buf_we;
    logic [AW-1:0]        buf_waddr;
    logic [AW-1:0]        buf_raddr;
    logic [SAMPLE_W-1:0]  rd_data;

    nirs_sample_buf #(
        .N_DET (N_DET),
        .AW    (AW)
    ) u_buf (
        .clock (clock),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (sample_data),
        .raddr (buf_raddr),
        .rdata (rd_data)
    );

    // 14-bit subtraction so a bogus used-word count cannot wrap into "plenty of room".
    assign free_space = DEPTH_14 - {1'b0, fifo_wrusedw};
    assign accept     = tx_active & ~fifo_full;
    assign buf_we     = (state == COLLECT) && sample_valid;
    assign buf_waddr  = scan_start ? '0 : AW'(sidx);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (scan_start) state_nx = COLLECT;
            end
            COLLECT: begin
                if (scan_start) begin
                    if (sample_valid && N_DET == 1) state_nx = WAIT_SPACE;
                end else if (sample_valid && sidx == LAST_IDX) begin
                    state_nx = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (free_space >= FB_14) state_nx = HEADER;
            end
            HEADER: begin
                if (!fifo_full && bidx == 2'd3) state_nx = DATA;
            end
            DATA: begin
                if (!fifo_full && bidx == 2'd2 && sidx == LAST_IDX) state_nx = CHECKSUM;
            end
            CHECKSUM: begin
                if (!fifo_full) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read address runs one step ahead of the byte pointer so the registered
    // buffer output is ready on the cycle its first byte is sent.
    always_comb begin
        tx_active = 1'b0;
        csum_add  = 1'b0;
        tx_byte   = 8'h00;
        buf_raddr = AW'(sidx);
        case (state)
            HEADER: begin
                tx_active = 1'b1;
                buf_raddr = '0;
                case (bidx)
                    2'd0:    tx_byte = SYNC0;
                    2'd1:    tx_byte = SYNC1;
                    2'd2:    begin tx_byte = frame_cnt;        csum_add = 1'b1; end
                    default: begin tx_byte = {3'b000, src_q};  csum_add = 1'b1; end
                endcase
            end
            DATA: begin
                tx_active = 1'b1;
                csum_add  = 1'b1;
                case (bidx)
                    2'd0:    tx_byte = rd_data[23:16];
                    2'd1:    tx_byte = rd_data[15:8];
                    default: tx_byte = rd_data[7:0];
                endcase
                if (!fifo_full && bidx == 2'd2) buf_raddr = AW'(sidx + 1'b1);
            end
            CHECKSUM: begin
                tx_active = 1'b1;
                tx_byte   = csum;
            end
            default: ;
        endcase
    end

    assign busy    = (state != IDLE);
    assign ovf_set = ((state == IDLE) && sample_valid)
                   || ((state == COLLECT) && scan_start)
                   || ((state inside {WAIT_SPACE, HEADER, DATA, CHECKSUM})
                       && (scan_start || sample_valid));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sidx         <= '0;
            bidx         <= 2'd0;
            csum         <= 8'h00;
            frame_cnt    <= 8'h00;
            ovf_err      <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= 8'h00;
        end else begin
            fifo_wr_en <= accept;
            if (accept) fifo_data_in <= tx_byte;
            if (accept && csum_add) csum <= csum + tx_byte;
            if (ovf_set) ovf_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (scan_start) sidx <= '0;
                end
                COLLECT: begin
                    if (scan_start) begin
                        sidx <= sample_valid ? IW'(1) : '0;
                    end else if (sample_valid) begin
                        sidx <= sidx + 1'b1;
                    end
                end
                WAIT_SPACE: begin
                    sidx <= '0;
                    bidx <= 2'd0;
                    csum <= 8'h00;
                end
                HEADER: begin
                    if (!fifo_full) bidx <= bidx + 2'd1;
                end
                DATA: begin
                    if (!fifo_full) begin
                        if (bidx == 2'd2) begin
                            bidx <= 2'd0;
                            sidx <= sidx + 1'b1;
                        end else begin
                            bidx <= bidx + 2'd1;
                        end
                    end
                end
                CHECKSUM: begin
                    if (!fifo_full) frame_cnt <= frame_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (scan_start && (state == IDLE || state == COLLECT)) begin
            src_q <= source_idx;
        end
    end

endmodule

// File: tb/tb_nirs_frame_packer.sv
// Directed bench for nirs_frame_packer: table of whole-frame vectors plus hand sequences.
module tb_nirs_frame_packer;

    localparam int FB = 101;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        scan_start;
    logic [4:0]  source_idx;
    logic        sample_valid;
    logic [23:0] sample_data;
    logic [12:0] fifo_wrusedw;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data_in;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic        ovf_err;

    nirs_frame_packer dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .scan_start   (scan_start),
        .source_idx   (source_idx),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .fifo_wrusedw (fifo_wrusedw),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .ovf_err      (ovf_err)
    );

    always #5 clock = ~clock;

    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always @(negedge clock) begin
        if (rst_n && fifo_wr_en) cap.push_back(fifo_data_in);
    end

    typedef struct {
        logic [4:0]  src;
        bit          ramp;
        logic [23:0] base;
        bit          stall;
        logic [7:0]  csum;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    task automatic drive_cycle();
        @(posedge clock);
        #1;
    endtask

    // Reference frame: sync, count, source, samples MSB first, 8-bit sum from count on.
    task automatic build_expected(input logic [7:0] cnt, input logic [4:0] src,
                                  input bit ramp, input logic [23:0] base);
        logic [7:0]  sum;
        logic [23:0] s;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(cnt);
        exp_q.push_back({3'b000, src});
        sum = cnt + {3'b000, src};
        for (int k = 0; k < 32; k++) begin
            s = ramp ? 24'(k + 1) : base;
            exp_q.push_back(s[23:16]);
            exp_q.push_back(s[15:8]);
            exp_q.push_back(s[7:0]);
            sum = sum + s[23:16] + s[15:8] + s[7:0];
        end
        exp_q.push_back(sum);
    endtask

    task automatic scan(input logic [4:0] src, input bit ramp, input logic [23:0] base,
                        input int n, input bit overlap);
        scan_start   = 1'b1;
        source_idx   = src;
        sample_valid = overlap;
        sample_data  = ramp ? 24'd1 : base;
        drive_cycle();
        scan_start = 1'b0;
        for (int k = (overlap ? 1 : 0); k < n; k++) begin
            sample_valid = 1'b1;
            sample_data  = ramp ? 24'(k + 1) : base;
            drive_cycle();
        end
        sample_valid = 1'b0;
    endtask

    task automatic wait_frame(input string name, input bit stall, input int inject_at);
        int  cyc = 0;
        bit  injected = 0;
        while (!(cap.size() >= FB && !busy) && cyc < 3000) begin
            fifo_full    = stall && (cyc % 3 == 0);
            sample_valid = 1'b0;
            if (!injected && inject_at >= 0 && cap.size() == inject_at) begin
                sample_valid = 1'b1;
                sample_data  = 24'h5A5A5A;
                injected     = 1;
            end
            drive_cycle();
            cyc++;
        end
        fifo_full    = 1'b0;
        sample_valid = 1'b0;
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_frame(input string name);
        int bad = 0;
        int first = -1;
        int n;
        check({name, "_len"}, cap.size(), exp_q.size());
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (cap[i] !== exp_q[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        check($sformatf("%s_bytes(first diff at %0d)", name, first), bad, 0);
    endtask

    function automatic logic [7:0] last_byte();
        return (cap.size() > 0) ? cap[cap.size() - 1] : 8'h00;
    endfunction

    initial begin
        vecs[0] = '{src: 5'd5,  ramp: 1'b1, base: 24'h000000, stall: 1'b0, csum: 8'h15};
        vecs[1] = '{src: 5'd31, ramp: 1'b1, base: 24'h000000, stall: 1'b1, csum: 8'h30};
        vecs[2] = '{src: 5'd0,  ramp: 1'b0, base: 24'hFFFFFF, stall: 1'b0, csum: 8'hA2};
        vecs[3] = '{src: 5'd17, ramp: 1'b0, base: 24'h800000, stall: 1'b1, csum: 8'h14};
        vecs[4] = '{src: 5'd9,  ramp: 1'b0, base: 24'h123456, stall: 1'b0, csum: 8'h8D};

        rst_n        = 1'b0;
        scan_start   = 1'b0;
        source_idx   = 5'd0;
        sample_valid = 1'b0;
        sample_data  = 24'd0;
        fifo_wrusedw = 13'd0;
        fifo_full    = 1'b0;
        #3;
        check("rst_wr_en", {31'd0, fifo_wr_en}, 0);
        check("rst_data", {24'd0, fifo_data_in}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_frame_cnt", {24'd0, frame_cnt}, 0);
        check("rst_ovf", {31'd0, ovf_err}, 0);
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
        drive_cycle();

        for (int i = 0; i < 5; i++) begin
            cap.delete();
            build_expected(8'(i), vecs[i].src, vecs[i].ramp, vecs[i].base);
            scan(vecs[i].src, vecs[i].ramp, vecs[i].base, 32, 1'b0);
            wait_frame($sformatf("vec%0d", i), vecs[i].stall, -1);
            check_frame($sformatf("vec%0d", i));
            check($sformatf("vec%0d_csum", i), {24'd0, last_byte()}, {24'd0, vecs[i].csum});
            check($sformatf("vec%0d_frame_cnt", i), {24'd0, frame_cnt}, i + 1);
        end
        check("ovf_after_table", {31'd0, ovf_err}, 0);

        // Space gate: free 92 and 100 hold the frame, free 101 releases it.
        cap.delete();
        build_expected(8'd5, 5'd3, 1'b1, 24'd0);
        fifo_wrusedw = 13'd8100;
        scan(5'd3, 1'b1, 24'd0, 32, 1'b0);
        repeat (20) drive_cycle();
        check("gate_8100_writes", cap.size(), 0);
        check("gate_8100_busy", {31'd0, busy}, 1);
        fifo_wrusedw = 13'd8092;
        repeat (5) drive_cycle();
        check("gate_8092_writes", cap.size(), 0);
        fifo_wrusedw = 13'd8091;
        drive_cycle();
        check("gate_open_wr_en_c1", {31'd0, fifo_wr_en}, 0);
        drive_cycle();
        check("gate_open_wr_en_c2", {31'd0, fifo_wr_en}, 1);
        check("gate_open_sync0", {24'd0, fifo_data_in}, 32'hA5);
        fifo_wrusedw = 13'd0;
        wait_frame("gate", 1'b0, -1);
        check_frame("gate");
        check("gate_csum", {24'd0, last_byte()}, 32'h18);

        // Overrun: restart after 10 samples; new start carries the first sample.
        check("ovf_before_overrun", {31'd0, ovf_err}, 0);
        cap.delete();
        build_expected(8'd6, 5'd12, 1'b1, 24'd0);
        scan(5'd2, 1'b0, 24'hABCDEF, 10, 1'b0);
        scan(5'd12, 1'b1, 24'd0, 32, 1'b1);
        check("overrun_ovf", {31'd0, ovf_err}, 1);
        wait_frame("overrun", 1'b0, -1);
        check_frame("overrun");
        check("overrun_csum", {24'd0, last_byte()}, 32'h22);

        // Reset in the middle of the data phase.
        cap.delete();
        scan(5'd7, 1'b1, 24'd0, 32, 1'b0);
        for (int c = 0; c < 500 && cap.size() < 40; c++) drive_cycle();
        check("rst_mid_pre_wr_en", {31'd0, fifo_wr_en}, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wr_en", {31'd0, fifo_wr_en}, 0);
        check("rst_mid_data", {24'd0, fifo_data_in}, 0);
        check("rst_mid_busy", {31'd0, busy}, 0);
        check("rst_mid_frame_cnt", {24'd0, frame_cnt}, 0);
        check("rst_mid_ovf", {31'd0, ovf_err}, 0);
        repeat (2) drive_cycle();
        rst_n = 1'b1;
        drive_cycle();

        // Wrap: 257 frames carry counts 00..FF then 00; one frame is poked while busy.
        for (int f = 0; f < 257; f++) begin
            logic [7:0]  fb;
            logic [23:0] base;
            fb   = 8'(f);
            base = {fb, ~fb, 8'h3C};
            cap.delete();
            build_expected(fb, fb[4:0], 1'b0, base);
            if (f == 100) check("wrap_ovf_before_poke", {31'd0, ovf_err}, 0);
            scan(fb[4:0], 1'b0, base, 32, 1'b0);
            wait_frame($sformatf("wrap%0d", f), (f % 5 == 2), (f == 100) ? 30 : -1);
            check_frame($sformatf("wrap%0d", f));
            if (f == 100) check("wrap_ovf_after_poke", {31'd0, ovf_err}, 1);
        end
        check("wrap_final_frame_cnt", {24'd0, frame_cnt}, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
